// File: rtl/ledseg_out_pkg.sv
// Shared constants for the LED / seven-segment output peripheral: register
// addresses, default scan divider and the hex-digit segment pattern table.
package ledseg_out_pkg;

  // Register select values on ledaddr; 3'b011 and 3'b111 are unused.
  localparam logic [2:0] LED_LO = 3'b000;  // led[7:0]   <= wdata[7:0]
  localparam logic [2:0] LED_HI = 3'b001;  // led[15:8]  <= wdata[7:0]
  localparam logic [2:0] LED_HW = 3'b010;  // led        <= wdata
  localparam logic [2:0] SEG_LO = 3'b100;  // segdata[15:0]  <= wdata
  localparam logic [2:0] SEG_HI = 3'b101;  // segdata[31:16] <= wdata
  localparam logic [2:0] SEG_EN = 3'b110;  // segen <= wdata[7:0]

  // ledclk cycles per digit slot: 1 kHz per digit at 100 MHz.
  localparam int unsigned SCAN_DIV_DEFAULT = 100000;

  // Segment patterns, bit0=a .. bit6=g; entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,  // F E d C b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F   // 7 6 5 4 3 2 1 0
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to seven-segment pattern decoder.
module hex_to_seg
  import ledseg_out_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Pure table lookup.
  always_comb begin
    seg_o = SEG_TABLE[hex_i];
  end

endmodule

// File: rtl/ledseg_out.sv
// Memory-mapped LED and 8-digit multiplexed seven-segment output peripheral.
// All state changes on the falling edge of ledclk; switrst clears everything
// asynchronously.
module ledseg_out
  import ledseg_out_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic        ledclk,
  input  logic        switrst,
  input  logic        ledcs,
  input  logic        ledwrite,
  input  logic [2:0]  ledaddr,
  input  logic [15:0] ledwdata,
  output logic [15:0] led_out,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  logic [15:0]     led_q, led_d;
  logic [31:0]     segdata_q, segdata_d;
  logic [7:0]      segen_q, segen_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      an_q, an_d;
  logic [7:0]      seg_q, seg_d;
  logic            wrap;
  logic [3:0]      nib;
  logic [6:0]      pat;

  // Register writes: only a qualified strobe changes state, unused addresses are dropped.
  always_comb begin
    led_d     = led_q;
    segdata_d = segdata_q;
    segen_d   = segen_q;
    if (ledcs && ledwrite) begin
      case (ledaddr)
        LED_LO:  led_d[7:0]       = ledwdata[7:0];
        LED_HI:  led_d[15:8]      = ledwdata[7:0];
        LED_HW:  led_d            = ledwdata;
        SEG_LO:  segdata_d[15:0]  = ledwdata;
        SEG_HI:  segdata_d[31:16] = ledwdata;
        SEG_EN:  segen_d          = ledwdata[7:0];
        default: ;
      endcase
    end
  end

  // Free-running scan: slot counter wraps at SCAN_DIV and advances the digit index.
  always_comb begin
    wrap  = (cnt_q == CntMax);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? idx_q + 3'd1 : idx_q;
  end

  assign nib = segdata_q[{idx_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .hex_i (nib),
    .seg_o (pat)
  );

  // Display drive for the current digit; registered so outputs switch cleanly per edge.
  always_comb begin
    an_d  = 8'h00;
    seg_d = 8'h00;
    if (segen_q[idx_q]) begin
      an_d  = 8'h01 << idx_q;
      seg_d = {1'b0, pat};
    end
  end

  // State and output registers.
  always_ff @(negedge ledclk or posedge switrst) begin
    if (switrst) begin
      led_q     <= '0;
      segdata_q <= '0;
      segen_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      an_q      <= '0;
      seg_q     <= '0;
    end else begin
      led_q     <= led_d;
      segdata_q <= segdata_d;
      segen_q   <= segen_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign led_out = led_q;
  assign seg_an  = an_q;
  assign seg_out = seg_q;

endmodule

// File: tb/tb_ledseg_out.sv
// Self-checking bench for ledseg_out with SCAN_DIV=4 and a behavioural model.
module tb_ledseg_out;

  localparam int unsigned DIV = 4;
  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        switrst = 1'b1;
  logic        ledcs = 1'b0;
  logic        ledwrite = 1'b0;
  logic [2:0]  ledaddr = 3'b000;
  logic [15:0] ledwdata = 16'h0000;
  logic [15:0] led_out;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;

  int total = 0;
  int bad = 0;

  // Model: edges elapsed since reset release, plus register contents.
  int unsigned n;
  logic [15:0] m_led;
  logic [31:0] m_segdata;
  logic [7:0]  m_segen;
  logic [7:0]  m_an;
  logic [7:0]  m_seg;

  ledseg_out #(.SCAN_DIV(DIV)) dut (
    .ledclk   (clk),
    .switrst  (switrst),
    .ledcs    (ledcs),
    .ledwrite (ledwrite),
    .ledaddr  (ledaddr),
    .ledwdata (ledwdata),
    .led_out  (led_out),
    .seg_an   (seg_an),
    .seg_out  (seg_out)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    n = 0; m_led = '0; m_segdata = '0; m_segen = '0; m_an = '0; m_seg = '0;
  endtask

  // Apply inputs for one falling edge and advance the model; returns #1 after the edge.
  task automatic step(input logic cs, input logic we, input logic [2:0] a,
                      input logic [15:0] d);
    int unsigned i;
    int unsigned h;
    ledcs = cs; ledwrite = we; ledaddr = a; ledwdata = d;
    @(negedge clk);
    i = (n / DIV) % 8;
    h = (m_segdata >> (4 * i)) & 32'hF;
    if (m_segen[i]) begin
      m_an  = 8'(1 << i);
      m_seg = {1'b0, PAT[h]};
    end else begin
      m_an  = 8'h00;
      m_seg = 8'h00;
    end
    if (cs && we) begin
      if (a == 3'b000) m_led[7:0] = d[7:0];
      else if (a == 3'b001) m_led[15:8] = d[7:0];
      else if (a == 3'b010) m_led = d;
      else if (a == 3'b100) m_segdata[15:0] = d;
      else if (a == 3'b101) m_segdata[31:16] = d;
      else if (a == 3'b110) m_segen = d[7:0];
    end
    n++;
    #1;
    ledcs = 1'b0; ledwrite = 1'b0;
  endtask

  task automatic test_reset();
    switrst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({led_out, seg_an, seg_out} !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold: got %h want 0", {led_out, seg_an, seg_out});
    end
    switrst = 1'b0;
    for (int k = 0; k < 64; k++) begin
      step(1'b0, 1'b0, 3'b000, 16'h0000);
      total++;
      if (led_out !== 16'h0 || seg_an !== 8'h0 || seg_out !== 8'h0) begin
        bad++;
        $display("FAIL reset_idle k=%0d: got %h/%h/%h want 0/0/0", k, led_out, seg_an, seg_out);
      end
    end
  endtask

  task automatic test_led();
    step(1'b1, 1'b1, 3'b010, 16'hA5C3);
    total++;
    if (led_out !== 16'hA5C3) begin
      bad++; $display("FAIL led_hw: got %h want a5c3", led_out);
    end
    step(1'b1, 1'b1, 3'b001, 16'h007E);
    total++;
    if (led_out !== 16'h7EC3) begin
      bad++; $display("FAIL led_hi: got %h want 7ec3", led_out);
    end
    step(1'b0, 1'b1, 3'b010, 16'hA5C3);
    step(1'b0, 1'b1, 3'b001, 16'h0012);
    total++;
    if (led_out !== 16'h7EC3) begin
      bad++; $display("FAIL led_nocs: got %h want 7ec3", led_out);
    end
    step(1'b1, 1'b0, 3'b010, 16'h1111);
    total++;
    if (led_out !== 16'h7EC3) begin
      bad++; $display("FAIL led_nowe: got %h want 7ec3", led_out);
    end
    step(1'b1, 1'b1, 3'b000, 16'hFF9D);
    total++;
    if (led_out !== 16'h7E9D) begin
      bad++; $display("FAIL led_lo: got %h want 7e9d", led_out);
    end
  endtask

  task automatic test_scan();
    step(1'b1, 1'b1, 3'b100, 16'h3210);
    step(1'b1, 1'b1, 3'b101, 16'h7654);
    step(1'b1, 1'b1, 3'b110, 16'h00FF);
    for (int k = 0; k < 72; k++) begin
      step(1'b0, 1'b0, 3'b000, 16'h0000);
      total++;
      if (seg_an !== m_an || seg_out !== m_seg || led_out !== m_led) begin
        bad++;
        $display("FAIL scan k=%0d: got an=%h seg=%h want an=%h seg=%h", k, seg_an, seg_out,
                 m_an, m_seg);
      end
    end
  endtask

  task automatic test_sparse();
    step(1'b1, 1'b1, 3'b110, 16'h0005);
    step(1'b1, 1'b1, 3'b100, 16'h00BF);
    step(1'b1, 1'b1, 3'b101, 16'h0000);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b0, 3'b000, 16'h0000);
      total++;
      if (seg_an !== m_an || seg_out !== m_seg) begin
        bad++;
        $display("FAIL sparse k=%0d: got an=%h seg=%h want an=%h seg=%h", k, seg_an, seg_out,
                 m_an, m_seg);
      end
    end
  endtask

  task automatic test_wrap_write();
    logic [15:0] led_before;
    step(1'b1, 1'b1, 3'b110, 16'h0001);
    step(1'b1, 1'b1, 3'b100, 16'h0000);
    while ((n % (8 * DIV)) != (8 * DIV - 1)) step(1'b0, 1'b0, 3'b000, 16'h0000);
    step(1'b1, 1'b1, 3'b100, 16'h000E);
    step(1'b0, 1'b0, 3'b000, 16'h0000);
    total++;
    if (seg_an !== 8'h01 || seg_out !== 8'h79) begin
      bad++;
      $display("FAIL wrap_write: got an=%h seg=%h want an=01 seg=79", seg_an, seg_out);
    end
    led_before = led_out;
    for (int k = 0; k < 2 * DIV; k++) begin
      step(1'b1, 1'b1, 3'b111, 16'($urandom));
      total++;
      if (led_out !== led_before || seg_an !== m_an || seg_out !== m_seg) begin
        bad++;
        $display("FAIL addr111 k=%0d: got %h/%h/%h want %h/%h/%h", k, led_out, seg_an, seg_out,
                 led_before, m_an, m_seg);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] a;
    for (int k = 0; k < 400; k++) begin
      a = 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), a, 16'($urandom));
      total++;
      if (led_out !== m_led || seg_an !== m_an || seg_out !== m_seg) begin
        bad++;
        $display("FAIL random k=%0d: got %h/%h/%h want %h/%h/%h", k, led_out, seg_an, seg_out,
                 m_led, m_an, m_seg);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b1, 3'b110, 16'h00FF);
    step(1'b1, 1'b1, 3'b010, 16'hBEEF);
    while (((n / DIV) % 8) != 5 || (n % DIV) != 2) step(1'b0, 1'b0, 3'b000, 16'h0000);
    #2;
    switrst = 1'b1;
    #1;
    total++;
    if ({led_out, seg_an, seg_out} !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset_async: got %h want 0", {led_out, seg_an, seg_out});
    end
    model_clear();
    @(negedge clk);
    #1;
    switrst = 1'b0;
    step(1'b1, 1'b1, 3'b110, 16'h00FF);
    step(1'b1, 1'b1, 3'b100, 16'h3210);
    for (int k = 0; k < 3 * DIV; k++) begin
      step(1'b0, 1'b0, 3'b000, 16'h0000);
      total++;
      if (seg_an !== m_an || seg_out !== m_seg || led_out !== 16'h0) begin
        bad++;
        $display("FAIL after_reset k=%0d: got %h/%h/%h want 0000/%h/%h", k, led_out, seg_an,
                 seg_out, m_an, m_seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_led();
    test_scan();
    test_sparse();
    test_wrap_write();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ledseg_out.md
LEDSEG_OUT -- requirements
Module: ledseg_out

Interface
REQ-001 Parameter SCAN_DIV, default 100000, ledclk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20.
REQ-002 ledclk  input  1  CPU/peripheral clock; all state updates on its negative edge.
REQ-003 switrst  input  1  reset, asynchronous, active-high.
REQ-004 ledcs  input  1  chip-select from memorio.
REQ-005 ledwrite  input  1  write strobe from memorio.
REQ-006 ledaddr  input  3  register select.
REQ-007 ledwdata  input  16  write data from CPU.
REQ-008 led_out  output  16  board LED drive, active-high.
REQ-009 seg_an  output  8  digit enables, active-high, bit i = digit i (digit 0 rightmost).
REQ-010 seg_out  output  8  segments, active-high: bit0=a … bit6=g, bit7=dp.

Function
REQ-011 A write SHALL occur on a negedge of ledclk only when ledcs=1 and ledwrite=1; otherwise every register holds.
REQ-012 The ledaddr decode SHALL be: 000 led[7:0]<=ledwdata[7:0]; 001 led[15:8]<=ledwdata[7:0]; 010 led<=ledwdata; 100 segdata[15:0]<=ledwdata; 101 segdata[31:16]<=ledwdata; 110 segen<=ledwdata[7:0]; 011/111 ignored, no state change.
REQ-013 Partial-byte writes SHALL leave the other byte of led unchanged.
REQ-014 led_out SHALL equal the led register directly; write-to-output latency is zero cycles after the writing edge.
REQ-015 The scan counter SHALL count 0..SCAN_DIV-1 on each negedge and wrap to 0; on wrap, the 3-bit digit index SHALL increment, 7 wrapping to 0.
REQ-016 For digit index i, with segen[i]=1: seg_an SHALL be one-hot bit i and seg_out SHALL be the hex pattern of segdata[4i+3:4i]; with segen[i]=0: seg_an=0 and seg_out=0.
REQ-017 The hex patterns (seg_out[6:0]) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; dp (bit7) is always 0.
REQ-018 seg_an and seg_out SHALL be registered, updated on the same negedge as the index/data, so they never glitch between digits.
REQ-019 When a write and a scan wrap occur on the same edge, both SHALL take effect; the registered display outputs SHALL reflect the new data and new index from the edge after.
REQ-020 A write to segdata/segen SHALL NOT reset or disturb the scan counter or digit index.

Reset
REQ-021 While switrst=1, led, segdata, segen, the scan counter and the digit index SHALL be 0, and led_out, seg_an and seg_out SHALL be 0.
REQ-022 Reset asserted mid-scan SHALL take effect immediately without waiting for a clock edge; after release, scanning SHALL restart at digit 0 with count 0.

Structure
REQ-023 The shared package SHALL hold the address constants (LED_LO, LED_HI, LED_HW, SEG_LO, SEG_HI, SEG_EN), the SCAN_DIV default and the 16-entry segment pattern table.
REQ-024 The hex-to-segment decoder SHALL be a combinational sub-module named hex_to_seg (4-bit in, 7-bit out), instantiated once on the selected nibble.

Verification (SCAN_DIV=4)
REQ-025 Reset release, no writes -> led_out=0000, seg_an=00, seg_out=00 for 64 cycles.
REQ-026 Write addr 010 data A5C3, then addr 001 data 007E -> led_out=A5C3, then 7EC3; the same writes with ledcs=0 -> no change.
REQ-027 Write addr 100=3210, addr 101=7654, addr 110=00FF -> seg_an cycles 01,02,…,80,01 every 4 cycles, with seg_out 3F,06,5B,4F,66,6D,7D,07 respectively.
REQ-028 segen=05, segdata=0000_00BF -> digit 0 shows 71, digit 2 shows 3F, and all other slots have seg_an=00, seg_out=00.
REQ-029 Write segdata[15:0]=000E on the edge where digit 0 is entered -> digit 0 shows 79 from the next edge; write to addr 111 -> no register changes.
REQ-030 Assert switrst at index 5 -> all outputs 0 immediately; after release, first active slot is digit 0 after a full 4 cycles.
